ahb_resp_mux_n: RTL and testbench
=================================

Name: ahb_resp_mux_n

Overview:
Parametrised AHB-Lite slave-to-master response multiplexor for NUM_SLAVES slaves. It registers the decoder select during the address phase and uses it to route hrdata/hreadyout/hresp during the following data phase. It contains a built-in default slave that returns the AHB two-cycle ERROR response for unmapped or ambiguous accesses. It sits between the address decoder and the slave bank, and drives the master's read-data and ready/response inputs.

Parameters:
NUM_SLAVES, 4, number of slave channels (1..16)
DATA_WIDTH, 32, hrdata width per slave (8, 16, 32 or 64)

Ports:
hclk  in  1  bus clock; all state on rising edge
hresetn  in  1  asynchronous active-low reset
hsel_vec  in  NUM_SLAVES  address-phase select from decoder; one-hot expected
htrans  in  2  address-phase transfer type from master
hrdata_s  in  NUM_SLAVES*DATA_WIDTH  slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
hreadyout_s  in  NUM_SLAVES  per-slave hreadyout
hresp_s  in  NUM_SLAVES  per-slave hresp (1 = ERROR)
hrdata  out  DATA_WIDTH  muxed read data to master
hready  out  1  muxed ready; also broadcast to slaves as hready
hresp  out  1  muxed response
dflt_active  out  1  high while the data phase belongs to the default slave
multi_sel_err  out  1  sticky flag: multi-hot hsel_vec was sampled on an active transfer

Behaviour:
- Clock and reset: single clock domain hclk. Asynchronous active-low reset hresetn clears all state.
- Reset values: dsel = 0, ds_state = DS_IDLE, multi_sel_err = 0.
  - Resulting outputs: hrdata = 0, hready = 1, hresp = 0, dflt_active = 0.
- Address-phase sampling: state updates only on a rising edge with hready == 1 (the module's own output); otherwise all state holds. Let active = htrans[1] (NONSEQ or SEQ).
  - hsel_vec exactly one-hot: dsel <= hsel_vec; ds_state -> DS_IDLE.
  - hsel_vec all-zero and active: dsel <= 0; ds_state -> DS_ERR1.
  - hsel_vec multi-hot and active: dsel <= 0; ds_state -> DS_ERR1; multi_sel_err <= 1.
  - hsel_vec zero or multi-hot and not active (IDLE/BUSY): dsel <= 0; ds_state -> DS_IDLE.
- Data-phase outputs (combinational from dsel, ds_state and slave inputs; zero added latency):
  - dsel one-hot: hrdata/hready/hresp come from that slave; dflt_active = 0.
  - dsel == 0, DS_IDLE: hrdata = 0, hready = 1, hresp = 0 (default OKAY, zero wait).
  - DS_ERR1: hrdata = 0, hready = 0, hresp = 1, dflt_active = 1.
  - DS_ERR2: hrdata = 0, hready = 1, hresp = 1, dflt_active = 1.
- Default-slave FSM (DS_IDLE, DS_ERR1, DS_ERR2):
  - DS_ERR1 -> DS_ERR2 unconditionally on the next edge. hready = 0 in DS_ERR1, so no address sampling occurs in that cycle.
  - DS_ERR2 -> next state is chosen by the address-phase sampling rules above (hready = 1).
  - Back-to-back unmapped active transfers therefore produce ERR1, ERR2, ERR1, ERR2, and so on.
- Slave wait states: while the selected slave drives hreadyout = 0, dsel holds. New hsel_vec/htrans values are ignored until hreadyout = 1.
- Slave ERROR pass-through: the slave's own two-cycle ERROR is forwarded unmodified; this module adds no extra cycles.
- Pipeline select: the select register is a one-cycle pipeline. The address phase in cycle N routes data in cycle N+1, or later if stretched by wait states.
- Reset mid-transfer: outputs return to the reset values immediately (asynchronously). An in-flight DS_ERR1/DS_ERR2 sequence is abandoned.
- multi_sel_err: cleared only by hresetn.
- Unused slave inputs: values from non-selected slaves have no effect on any output.

Test Plan:
1. Reset, then release: hready = 1, hresp = 0, hrdata = 0, dflt_active = 0, multi_sel_err = 0 before any transfer.
2. NUM_SLAVES = 4, DATA_WIDTH = 32, address phase with hsel_vec = 4'b0100, htrans = NONSEQ, slave 2 hrdata = 32'hCAFE_0002 -> next cycle hrdata = 32'hCAFE_0002, hresp = 0. Changing slave 0/1/3 data in that cycle has no effect.
3. Slave 1 selected, hreadyout_s[1] = 0 for 3 cycles while the decoder drives hsel_vec = 4'b0001 -> hready = 0 for 3 cycles and dsel remains slave 1. Slave 0 routes only after hreadyout_s[1] = 1.
4. hsel_vec = 0, htrans = NONSEQ -> next cycle hready = 0, hresp = 1, dflt_active = 1; following cycle hready = 1, hresp = 1. Same stimulus with htrans = IDLE -> hready = 1, hresp = 0.
5. hsel_vec = 4'b0011, htrans = SEQ -> two-cycle ERROR from the default slave, and multi_sel_err = 1 persists through 10 later clean transfers until hresetn is asserted.
6. Assert hresetn low during DS_ERR1 -> hready = 1, hresp = 0 asynchronously. After release, a transfer with hsel_vec = 4'b1000 routes slave 3 normally.

Source files
------------

// File: rtl/ahb_resp_mux_n_if.sv
// ahb_resp_mux_n_if
// Bundles the signals between the address decoder, the slave bank, the
// master and the response multiplexor ahb_resp_mux_n.
//   hsel_vec      decoder address-phase select (one-hot expected)
//   htrans        master address-phase transfer type
//   hrdata_s      packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   hreadyout_s   per-slave hreadyout
//   hresp_s       per-slave hresp (1 = ERROR)
//   hrdata        muxed read data to the master
//   hready        muxed ready (also broadcast back to the slaves)
//   hresp         muxed response
//   dflt_active   data phase owned by the built-in default slave
//   multi_sel_err sticky multi-hot select flag
// Modport "slave" is the multiplexor's view; "master" is the view of
// whatever drives the mux inputs and consumes its outputs.
interface ahb_resp_mux_n_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_SLAVES-1:0]            hsel_vec;
  logic [1:0]                       htrans;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s;
  logic [NUM_SLAVES-1:0]            hreadyout_s;
  logic [NUM_SLAVES-1:0]            hresp_s;
  logic [DATA_WIDTH-1:0]            hrdata;
  logic                             hready;
  logic                             hresp;
  logic                             dflt_active;
  logic                             multi_sel_err;

  modport slave (
    input  hsel_vec, htrans, hrdata_s, hreadyout_s, hresp_s,
    output hrdata, hready, hresp, dflt_active, multi_sel_err
  );

  modport master (
    output hsel_vec, htrans, hrdata_s, hreadyout_s, hresp_s,
    input  hrdata, hready, hresp, dflt_active, multi_sel_err
  );
endinterface

// File: rtl/ahb_resp_mux_n.sv
// ahb_resp_mux_n
// AHB-Lite slave-to-master response multiplexor for NUM_SLAVES slaves with a
// built-in default slave. The decoder select is registered during the
// address phase and steers hrdata/hready/hresp during the data phase.
// Unmapped (all-zero) or ambiguous (multi-hot) active transfers are answered
// by the default slave with the two-cycle AHB ERROR response.
// Ports:
//   hclk     bus clock, all state on the rising edge
//   hresetn  asynchronous active-low reset
//   bus      ahb_resp_mux_n_if.slave bundle (see interface header)
module ahb_resp_mux_n #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              hclk,
  input logic              hresetn,
  ahb_resp_mux_n_if.slave  bus
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  ds_state_e             state_q;
  logic [NUM_SLAVES-1:0] dsel_q;
  logic [NUM_SLAVES-1:0] dsel_d;
  logic                  multi_q;

  logic                  active;
  logic                  sel_any;
  logic                  sel_onehot;
  logic                  hready_w;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  rdy_sel;
  logic                  resp_sel;
  logic                  unused_htrans0;

  assign unused_htrans0 = bus.htrans[0];

  assign active     = bus.htrans[1];
  assign sel_any    = |bus.hsel_vec;
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign sel_onehot = sel_any &&
                      ((bus.hsel_vec & (bus.hsel_vec - 1'b1)) == '0);
  assign dsel_d     = sel_onehot ? bus.hsel_vec : '0;

  // Default-slave FSM and select register. Sampling happens only while the
  // mux itself reports ready; DS_ERR1 forces hready low so its exit to
  // DS_ERR2 must be unconditional.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= DS_IDLE;
      dsel_q  <= '0;
      multi_q <= 1'b0;
    end else if (state_q == DS_ERR1) begin
      state_q <= DS_ERR2;
      dsel_q  <= '0;
    end else if (hready_w) begin
      dsel_q <= dsel_d;
      if (!sel_onehot && active) begin
        state_q <= DS_ERR1;
        if (sel_any) begin
          multi_q <= 1'b1;
        end
      end else begin
        state_q <= DS_IDLE;
      end
    end
  end

  // AND-OR mux over the registered one-hot select; non-selected slaves are
  // masked out completely.
  always_comb begin
    rdata_sel = '0;
    rdy_sel   = 1'b0;
    resp_sel  = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        rdata_sel = rdata_sel | bus.hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
        rdy_sel   = rdy_sel | bus.hreadyout_s[i];
        resp_sel  = resp_sel | bus.hresp_s[i];
      end
    end
  end

  always_comb begin
    bus.hrdata      = '0;
    hready_w        = 1'b1;
    bus.hresp       = 1'b0;
    bus.dflt_active = 1'b0;
    case (state_q)
      DS_ERR1: begin
        hready_w        = 1'b0;
        bus.hresp       = 1'b1;
        bus.dflt_active = 1'b1;
      end
      DS_ERR2: begin
        bus.hresp       = 1'b1;
        bus.dflt_active = 1'b1;
      end
      default: begin
        if (|dsel_q) begin
          bus.hrdata = rdata_sel;
          hready_w   = rdy_sel;
          bus.hresp  = resp_sel;
        end
      end
    endcase
  end

  assign bus.hready        = hready_w;
  assign bus.multi_sel_err = multi_q;

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// tb_ahb_resp_mux_n
// Self-checking bench for ahb_resp_mux_n (NUM_SLAVES=4, DATA_WIDTH=32):
// a directed vector table, hand-written corner sequences, and randomized
// stimulus compared against a transaction-level reference model.
module tb_ahb_resp_mux_n;
  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;

  logic hclk;
  logic hresetn;

  ahb_resp_mux_n_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) bus ();

  ahb_resp_mux_n #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic base_data();
    bus.hrdata_s = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
  endtask

  task automatic drive(input logic [3:0] hsel, input logic [1:0] htrans,
                       input logic [3:0] rdy, input logic [3:0] resp);
    bus.hsel_vec    = hsel;
    bus.htrans      = htrans;
    bus.hreadyout_s = rdy;
    bus.hresp_s     = resp;
  endtask

  task automatic check_out(input string tag, input logic [31:0] r,
                           input logic y, input logic e, input logic d);
    check({tag, ".hrdata"}, {32'h0, bus.hrdata}, {32'h0, r});
    check({tag, ".hready"}, {63'h0, bus.hready}, {63'h0, y});
    check({tag, ".hresp"}, {63'h0, bus.hresp}, {63'h0, e});
    check({tag, ".dflt_active"}, {63'h0, bus.dflt_active}, {63'h0, d});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  hsel;
    logic [1:0]  htrans;
    logic [3:0]  rdy;
    logic [3:0]  resp;
    logic [31:0] e_rdata;
    logic        e_rdy;
    logic        e_resp;
    logic        e_dflt;
    logic        e_multi;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(input logic [3:0] hsel, input logic [1:0] htrans,
                              input logic [3:0] rdy, input logic [3:0] resp,
                              input logic [31:0] er, input logic ey,
                              input logic ee, input logic ed, input logic em);
    vec_t v;
    v.hsel = hsel; v.htrans = htrans; v.rdy = rdy; v.resp = resp;
    v.e_rdata = er; v.e_rdy = ey; v.e_resp = ee; v.e_dflt = ed; v.e_multi = em;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // m_sel: slave owning the data phase (-1 none); m_err: position in the
  // default-slave ERROR response (0 none, 1 first cycle, 2 second cycle).
  int m_sel;
  int m_err;
  bit m_multi;

  task automatic m_reset();
    m_sel   = -1;
    m_err   = 0;
    m_multi = 1'b0;
  endtask

  task automatic m_expect(output logic [31:0] r, output logic y,
                          output logic e, output logic d);
    r = '0; y = 1'b1; e = 1'b0; d = 1'b0;
    if (m_err == 1) begin
      y = 1'b0; e = 1'b1; d = 1'b1;
    end else if (m_err == 2) begin
      e = 1'b1; d = 1'b1;
    end else if (m_sel >= 0) begin
      r = bus.hrdata_s[m_sel*32 +: 32];
      y = bus.hreadyout_s[m_sel];
      e = bus.hresp_s[m_sel];
    end
  endtask

  task automatic m_edge(input logic rdy_now);
    int cnt;
    int idx;
    cnt = 0;
    idx = -1;
    if (m_err == 1) begin
      m_err = 2;
      m_sel = -1;
    end else if (rdy_now) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.hsel_vec[i]) begin
          cnt++;
          idx = i;
        end
      end
      if (cnt == 1) begin
        m_sel = idx;
        m_err = 0;
      end else begin
        m_sel = -1;
        m_err = bus.htrans[1] ? 1 : 0;
        if (cnt > 1 && bus.htrans[1]) m_multi = 1'b1;
      end
    end
  endtask

  task automatic model_cycle(input string tag);
    logic [31:0] r;
    logic y, e, d;
    #3;
    m_expect(r, y, e, d);
    check_out(tag, r, y, e, d);
    check({tag, ".multi_sel_err"}, {63'h0, bus.multi_sel_err}, {63'h0, m_multi});
    m_edge(y);
    tick();
  endtask

  task automatic rand_inputs();
    case ($urandom_range(0, 3))
      0:       bus.hsel_vec = 4'b0000;
      1, 2:    bus.hsel_vec = 4'b0001 << $urandom_range(0, 3);
      default: bus.hsel_vec = 4'($urandom);
    endcase
    bus.htrans      = 2'($urandom);
    bus.hreadyout_s = 4'($urandom | $urandom);
    bus.hresp_s     = 4'($urandom & $urandom & $urandom);
    for (int i = 0; i < 4; i++) bus.hrdata_s[i*32 +: 32] = $urandom;
  endtask

  initial begin
    vt[0]  = mk(4'b0100, 2'b10, 4'b1111, 4'b0000, 32'h0,         1, 0, 0, 0);
    vt[1]  = mk(4'b0000, 2'b00, 4'b1111, 4'b0000, 32'hCAFE_0002, 1, 0, 0, 0);
    vt[2]  = mk(4'b0000, 2'b10, 4'b1111, 4'b0000, 32'h0,         1, 0, 0, 0);
    vt[3]  = mk(4'b0000, 2'b00, 4'b1111, 4'b0000, 32'h0,         0, 1, 1, 0);
    vt[4]  = mk(4'b0010, 2'b10, 4'b1111, 4'b0000, 32'h0,         1, 1, 1, 0);
    vt[5]  = mk(4'b0001, 2'b10, 4'b1101, 4'b0000, 32'hCAFE_0001, 0, 0, 0, 0);
    vt[6]  = mk(4'b0001, 2'b10, 4'b1101, 4'b0000, 32'hCAFE_0001, 0, 0, 0, 0);
    vt[7]  = mk(4'b0001, 2'b10, 4'b1101, 4'b0000, 32'hCAFE_0001, 0, 0, 0, 0);
    vt[8]  = mk(4'b0001, 2'b10, 4'b1111, 4'b0000, 32'hCAFE_0001, 1, 0, 0, 0);
    vt[9]  = mk(4'b0000, 2'b00, 4'b1111, 4'b0000, 32'hCAFE_0000, 1, 0, 0, 0);
    vt[10] = mk(4'b0000, 2'b00, 4'b1111, 4'b0000, 32'h0,         1, 0, 0, 0);
    vt[11] = mk(4'b0011, 2'b11, 4'b1111, 4'b0000, 32'h0,         1, 0, 0, 0);
    vt[12] = mk(4'b1000, 2'b10, 4'b1111, 4'b0000, 32'h0,         0, 1, 1, 1);
    vt[13] = mk(4'b1000, 2'b10, 4'b1111, 4'b0000, 32'h0,         1, 1, 1, 1);
    vt[14] = mk(4'b0000, 2'b00, 4'b0111, 4'b1000, 32'hCAFE_0003, 0, 1, 0, 1);
    vt[15] = mk(4'b0000, 2'b00, 4'b1111, 4'b1000, 32'hCAFE_0003, 1, 1, 0, 1);
    vt[16] = mk(4'b0000, 2'b00, 4'b1111, 4'b0000, 32'h0,         1, 0, 0, 1);

    // Reset and release
    hresetn = 1'b0;
    drive(4'b0000, 2'b00, 4'b1111, 4'b0000);
    base_data();
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    #3;
    check_out("reset", 32'h0, 1'b1, 1'b0, 1'b0);
    check("reset.multi_sel_err", {63'h0, bus.multi_sel_err}, 64'h0);
    tick();

    // Directed table
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].hsel, vt[i].htrans, vt[i].rdy, vt[i].resp);
      #3;
      check_out($sformatf("vec%0d", i), vt[i].e_rdata, vt[i].e_rdy,
                vt[i].e_resp, vt[i].e_dflt);
      check($sformatf("vec%0d.multi_sel_err", i), {63'h0, bus.multi_sel_err},
            {63'h0, vt[i].e_multi});
      tick();
    end

    // Reset clears the sticky flag
    hresetn = 1'b0;
    #1;
    check("rst_clear.multi_sel_err", {63'h0, bus.multi_sel_err}, 64'h0);
    tick();
    hresetn = 1'b1;

    // Non-selected slave data must not reach hrdata
    drive(4'b0100, 2'b10, 4'b1111, 4'b0000);
    bus.hrdata_s[2*32 +: 32] = 32'hCAFE_0002;
    tick();
    drive(4'b0000, 2'b00, 4'b1111, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      bus.hrdata_s[0*32 +: 32] = $urandom;
      bus.hrdata_s[1*32 +: 32] = $urandom;
      bus.hrdata_s[3*32 +: 32] = $urandom;
      bus.hreadyout_s = {1'($urandom), 1'b1, 2'($urandom)};
      bus.hresp_s     = {1'($urandom), 1'b0, 2'($urandom)};
      #1;
      check($sformatf("isolate%0d.hrdata", k), {32'h0, bus.hrdata}, {32'h0, 32'hCAFE_0002});
      check($sformatf("isolate%0d.hresp", k), {63'h0, bus.hresp}, 64'h0);
    end
    tick();

    // Multi-hot select: ERROR, then sticky flag through 10 clean transfers
    base_data();
    drive(4'b0011, 2'b11, 4'b1111, 4'b0000);
    tick();
    drive(4'b0000, 2'b00, 4'b1111, 4'b0000);
    #1;
    check_out("multi.err1", 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    check_out("multi.err2", 32'h0, 1'b1, 1'b1, 1'b1);
    check("multi.flag", {63'h0, bus.multi_sel_err}, 64'h1);
    for (int k = 0; k < 10; k++) begin
      drive(4'b0001 << (k % 4), 2'b10, 4'b1111, 4'b0000);
      tick();
      check($sformatf("multi.clean%0d.hrdata", k), {32'h0, bus.hrdata},
            {32'h0, 32'hCAFE_0000 + 32'(k % 4)});
      check($sformatf("multi.clean%0d.flag", k), {63'h0, bus.multi_sel_err}, 64'h1);
    end
    drive(4'b0000, 2'b00, 4'b1111, 4'b0000);
    tick();

    // Asynchronous reset in the middle of DS_ERR1
    drive(4'b0000, 2'b10, 4'b1111, 4'b0000);
    tick();
    drive(4'b0000, 2'b00, 4'b1111, 4'b0000);
    #1;
    check_out("midrst.err1", 32'h0, 1'b0, 1'b1, 1'b1);
    hresetn = 1'b0;
    #1;
    check_out("midrst.async", 32'h0, 1'b1, 1'b0, 1'b0);
    check("midrst.flag", {63'h0, bus.multi_sel_err}, 64'h0);
    tick();
    hresetn = 1'b1;
    drive(4'b1000, 2'b10, 4'b1111, 4'b0000);
    tick();
    drive(4'b0000, 2'b00, 4'b1111, 4'b0000);
    #1;
    check_out("midrst.slave3", 32'hCAFE_0003, 1'b1, 1'b0, 1'b0);
    tick();

    // Randomized stimulus against the reference model
    hresetn = 1'b0;
    m_reset();
    tick();
    hresetn = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      if (n % 300 == 299) begin
        hresetn = 1'b0;
        m_reset();
        #2;
        check_out($sformatf("rnd%0d.rst", n), 32'h0, 1'b1, 1'b0, 1'b0);
        check($sformatf("rnd%0d.rst.flag", n), {63'h0, bus.multi_sel_err}, 64'h0);
        tick();
        hresetn = 1'b1;
      end else begin
        model_cycle($sformatf("rnd%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
